// File: rtl/icache_pkg.sv
// Shared types and helpers for the icache refill path.
// Holds the responder FSM states and the fill-pattern word helper.
package icache_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESPOND,
    IMEM_DRAIN
  } imem_state_e;

  localparam logic [7:0] FILL_PATTERN = 8'hAA;

  function automatic logic [31:0] fill_word(input logic [31:0] addr);
    return {FILL_PATTERN, addr[23:0]};
  endfunction

endpackage

// File: rtl/imem_word_array.sv
// DEPTH x 32 word store with per-word valid bits for imem_responder.
// Ports: clk/reset, one write port (wr_*), one registered read port (rd_*).
module imem_word_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  output logic          rd_valid
);

  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             fwd;

  // A write landing on the same edge as the read is returned by it.
  assign fwd = wr_en && (wr_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= fwd ? wr_data : mem[rd_idx];
      rd_valid <= fwd | valid[rd_idx];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for icache refills: returns one word per miss.
// Ports: clk/reset, miss/fetchaddr in, ifetch/iready/busy/served out, ld_* preload.
module imem_responder
  import icache_pkg::*;
#(
  parameter int          LATENCY   = 3,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss,
  input  logic [31:0] fetchaddr,
  output logic [31:0] ifetch,
  output logic        iready,
  output logic        busy,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [15:0] served
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  imem_state_e state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [31:0] req_addr, req_d;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        resp_inr;
  logic [31:0] resp_fill;

  imem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_arr (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (ld_en && in_range(ld_addr)),
    .wr_idx   (idx_of(ld_addr)),
    .wr_data  (ld_data),
    .rd_en    (rd_en),
    .rd_idx   (idx_of(rd_addr)),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IMEM_IDLE;
      cnt      <= '0;
      req_addr <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      req_addr <= req_d;
    end
  end

  // rd_en marks the edge that enters RESPOND; the word is read there.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req_addr;
    rd_en   = 1'b0;
    rd_addr = req_addr;
    unique case (state)
      IMEM_IDLE: begin
        if (miss) begin
          req_d   = fetchaddr;
          rd_addr = fetchaddr;
          if (LATENCY == 1) begin
            state_d = IMEM_RESPOND;
            rd_en   = 1'b1;
          end else begin
            state_d = IMEM_WAIT;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      IMEM_WAIT: begin
        cnt_d = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_d = IMEM_RESPOND;
          rd_en   = 1'b1;
        end
      end
      IMEM_RESPOND: state_d = IMEM_DRAIN;
      IMEM_DRAIN:   state_d = IMEM_IDLE;
      default:      state_d = IMEM_IDLE;
    endcase
  end

  // Range and fill word are captured with the read so ifetch holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_inr  <= 1'b0;
      resp_fill <= '0;
    end else if (rd_en) begin
      resp_inr  <= in_range(rd_addr);
      resp_fill <= fill_word(rd_addr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served <= '0;
    end else if (state == IMEM_RESPOND) begin
      served <= served + 16'd1;
    end
  end

  assign ifetch = (resp_inr && rd_valid) ? rd_data : resp_fill;
  assign iready = (state == IMEM_RESPOND);
  assign busy   = (state != IMEM_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder.
// Covers LATENCY=3 (main DUT) and LATENCY=1 (second DUT).
module tb_imem_responder;
  import icache_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss, ld_en;
  logic [31:0] fetchaddr, ld_addr, ld_data, ifetch;
  logic        iready, busy;
  logic [15:0] served;
  logic        miss1, ld_en1;
  logic [31:0] fetchaddr1, ld_addr1, ld_data1, ifetch1;
  logic        iready1, busy1;
  logic [15:0] served1;

  int n_checks = 0;
  int n_fail = 0;
  int exp_served = 0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .miss(miss), .fetchaddr(fetchaddr),
    .ifetch(ifetch), .iready(iready), .busy(busy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .served(served)
  );

  imem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .miss(miss1), .fetchaddr(fetchaddr1),
    .ifetch(ifetch1), .iready(iready1), .busy(busy1),
    .ld_en(ld_en1), .ld_addr(ld_addr1), .ld_data(ld_data1), .served(served1)
  );

  // Reference: 1 KiB window at address 0, word-indexed sparse store.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (a < 32'h400 && model_mem.exists(int'(a >> 2)))
      return model_mem[int'(a >> 2)];
    return fill_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (a < 32'h400) model_mem[int'(a >> 2)] = d;
  endtask

  task automatic req_and_check(input logic [31:0] a, input string nm);
    logic [31:0] exp;
    int lat;
    exp = model_word(a);
    lat = 0;
    @(negedge clk);
    miss = 1'b1; fetchaddr = a;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        miss = 1'b0; fetchaddr = $urandom;
      end
      if (iready === 1'b1) lat = n;
    end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT);
    end
    n_checks++;
    if (ifetch !== exp) begin
      n_fail++;
      $display("FAIL %s ifetch: got %h want %h", nm, ifetch, exp);
    end
    exp_served++;
    @(negedge clk);
    n_checks++;
    if (iready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobe width: iready %b want 0", nm, iready);
    end
    n_checks++;
    if (ifetch !== exp) begin
      n_fail++;
      $display("FAIL %s hold: got %h want %h", nm, ifetch, exp);
    end
    n_checks++;
    if (served !== 16'(exp_served)) begin
      n_fail++;
      $display("FAIL %s served: got %0d want %0d", nm, served, exp_served);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    miss = 0; fetchaddr = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    miss1 = 0; fetchaddr1 = 0; ld_en1 = 0; ld_addr1 = 0; ld_data1 = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({iready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: iready/busy %b%b want 00", iready, busy);
    end
    n_checks++;
    if (ifetch !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ifetch: got %h want 0", ifetch);
    end
    n_checks++;
    if (served !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_served: got %0d want 0", served);
    end
    reset = 1'b0;
    exp_served = 0;
    model_mem.delete();
    @(negedge clk);
  endtask

  task automatic test_fill();
    req_and_check(32'h0000_0010, "fill");
    n_checks++;
    if (ifetch !== 32'hAA00_0010) begin
      n_fail++;
      $display("FAIL fill_const: got %h want aa000010", ifetch);
    end
  endtask

  task automatic test_preload();
    preload(32'h0000_0010, 32'hDEAD_BEEF);
    req_and_check(32'h0000_0013, "preload");
  endtask

  task automatic test_out_of_range();
    req_and_check(32'hBB00_0010, "oor_req");
    preload(32'hBB00_0010, 32'h5555_5555);
    req_and_check(32'h0000_0010, "oor_ld");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: preload({26'($urandom_range(0, 15)), 2'($urandom)} & 32'h3F
                   , $urandom);
        1: begin
          a = $urandom;
          if (a < 32'h400) a = a | 32'h8000_0000;
          preload(a, $urandom);
        end
        2: begin
          a = $urandom;
          if (a < 32'h400) a = a | 32'h0100_0000;
          req_and_check(a, "rand_oor");
        end
        default: req_and_check(32'($urandom_range(0, 63)), "rand_hit");
      endcase
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int expn[$];
    for (int p = LAT; p <= 20; p += LAT + 2) expn.push_back(p);
    @(negedge clk);
    miss = 1'b1; fetchaddr = 32'h0000_0040;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (iready === 1'b1) pulses.push_back(n);
    end
    miss = 1'b0;
    repeat (4) @(negedge clk);
    exp_served += expn.size();
    n_checks++;
    if (pulses.size() != expn.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses want %0d",
               pulses.size(), expn.size());
    end
    for (int k = 0; k < expn.size() && k < pulses.size(); k++) begin
      n_checks++;
      if (pulses[k] != expn[k]) begin
        n_fail++;
        $display("FAIL b2b_pulse%0d: at cycle %0d want %0d",
                 k, pulses[k], expn[k]);
      end
    end
    n_checks++;
    if (served !== 16'(exp_served)) begin
      n_fail++;
      $display("FAIL b2b_served: got %0d want %0d", served, exp_served);
    end
    n_checks++;
    if (ifetch !== model_word(32'h40)) begin
      n_fail++;
      $display("FAIL b2b_ifetch: got %h want %h", ifetch, model_word(32'h40));
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    preload(32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    miss = 1'b1; fetchaddr = 32'h0000_0010;
    @(negedge clk);
    miss = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, iready} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_busy: busy/iready %b%b want 00", busy, iready);
    end
    n_checks++;
    if (served !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_served: got %0d want 0", served);
    end
    model_mem.delete();
    exp_served = 0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (iready !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_abort: iready rose want none");
    end
    req_and_check(32'h0000_0010, "mid_after");
  endtask

  task automatic test_latency1();
    @(negedge clk);
    miss1 = 1'b1; fetchaddr1 = 32'h20;
    ld_en1 = 1'b1; ld_addr1 = 32'h20; ld_data1 = 32'h1234_5678;
    @(negedge clk);
    miss1 = 1'b0; ld_data1 = 32'hCAFE_F00D;
    n_checks++;
    if (iready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL l1_iready: got %b want 1", iready1);
    end
    n_checks++;
    if (ifetch1 !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL l1_fwd: got %h want 12345678", ifetch1);
    end
    @(negedge clk);
    ld_en1 = 1'b0;
    n_checks++;
    if ({iready1, busy1} !== 2'b01) begin
      n_fail++;
      $display("FAIL l1_drain: iready/busy %b%b want 01", iready1, busy1);
    end
    n_checks++;
    if (ifetch1 !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL l1_hold: got %h want 12345678", ifetch1);
    end
    n_checks++;
    if (served1 !== 16'd1) begin
      n_fail++;
      $display("FAIL l1_served: got %0d want 1", served1);
    end
    @(negedge clk);
    miss1 = 1'b1; fetchaddr1 = 32'h22;
    @(negedge clk);
    miss1 = 1'b0;
    n_checks++;
    if (iready1 !== 1'b1 || ifetch1 !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL l1_second: iready %b ifetch %h want 1 cafef00d",
               iready1, ifetch1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_preload();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
